// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and a combinational
// instruction memory (slave).
interface if_id_fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_fetch_stage.sv
// RV32I fetch stage with the IF/ID pipeline register: PC sequencing, Execute
// redirects, hazard stall/flush, and a sticky misaligned-target flag.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       StallF,
    input  logic                       StallD,
    input  logic                       FlushD,
    input  logic                       PCSrcE,
    input  logic [31:0]                PCTargetE,
    if_id_fetch_stage_if.master        imem,
    output logic [31:0]                PCF,
    output logic [31:0]                instrD,
    output logic [31:0]                PCD,
    output logic [31:0]                PCPlus4D,
    output logic                       validD,
    output logic                       misaligned_err
);

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4d_q, pcplus4d_d;
    logic        valid_q, valid_d;
    logic        misal_q, misal_d;
    logic [31:0] pcplus4f;

    always_comb begin
        pcplus4f   = pcf_q + 32'd4;

        // Redirect beats StallF so a taken branch is never lost behind a stall
        pcf_d = pcf_q;
        if (PCSrcE)
            pcf_d = {PCTargetE[31:2], 2'b00};
        else if (!StallF)
            pcf_d = pcplus4f;

        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        valid_d    = valid_q;
        if (FlushD) begin
            instr_d    = NOP_INSTR;
            pcd_d      = '0;
            pcplus4d_d = '0;
            valid_d    = 1'b0;
        end else if (!StallD) begin
            instr_d    = imem.imem_rdata;
            pcd_d      = pcf_q;
            pcplus4d_d = pcplus4f;
            valid_d    = 1'b1;
        end

        misal_d = misal_q | (PCSrcE & (PCTargetE[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf_q      <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            valid_q    <= 1'b0;
            misal_q    <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            valid_q    <= valid_d;
            misal_q    <= misal_d;
        end
    end

    assign imem.imem_addr  = pcf_q;
    assign PCF             = pcf_q;
    assign instrD          = instr_q;
    assign PCD             = pcd_q;
    assign PCPlus4D        = pcplus4d_q;
    assign validD          = valid_q;
    assign misaligned_err  = misal_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: directed vector table, async-reset and wrap
// sequences, then random stimulus against a reference model.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;

    logic [31:0] PCF1, instrD1, PCD1, PCPlus4D1;
    logic        validD1, err1;
    logic [31:0] PCF2, instrD2, PCD2, PCPlus4D2;
    logic        validD2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    if_id_fetch_stage_if imem1 ();
    if_id_fetch_stage_if imem2 ();
    assign imem1.imem_rdata = mem_word(imem1.imem_addr);
    assign imem2.imem_rdata = mem_word(imem2.imem_addr);

    if_id_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u1 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(imem1.master),
        .PCF(PCF1), .instrD(instrD1), .PCD(PCD1), .PCPlus4D(PCPlus4D1),
        .validD(validD1), .misaligned_err(err1)
    );

    if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u2 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(imem2.master),
        .PCF(PCF2), .instrD(instrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2),
        .validD(validD2), .misaligned_err(err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic sf, input logic sd, input logic fd,
                          input logic ps, input logic [31:0] tgt);
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, ".PCF"},      PCF1,      32'h0);
        chk({tag, ".instrD"},   instrD1,   NOP);
        chk({tag, ".PCD"},      PCD1,      32'h0);
        chk({tag, ".PCPlus4D"}, PCPlus4D1, 32'h0);
        chk({tag, ".validD"},   {31'b0, validD1}, 32'h0);
        chk({tag, ".err"},      {31'b0, err1},    32'h0);
    endtask

    // Reference model: architectural view of the stage
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid, m_err;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] npc;
        if (PCSrcE)      npc = PCTargetE & ~32'd3;
        else if (StallF) npc = m_pc;
        else             npc = m_pc + 32'd4;
        if (FlushD) begin
            m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!StallD) begin
            m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        if (PCSrcE && (PCTargetE % 4 != 0)) m_err = 1'b1;
        m_pc = npc;
    endtask

    typedef struct {
        logic        sf, sd, fd, ps;
        logic [31:0] tgt;
        logic [31:0] e_pcf;
        logic        bub;
        logic [31:0] e_pcd;
        logic [31:0] e_pc4;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    initial begin
        vec_t v;
        logic [31:0] e_instr;

        rst = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        #12;
        chk_reset1("reset");
        @(negedge clk); rst = 1'b0;

        //            sf sd fd ps tgt            pcf           bub pcd           pc4          err
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h4,        0,  32'h0,        32'h4,       0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h8,        0,  32'h4,        32'h8,       0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'hC,        0,  32'h8,        32'hC,       0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h10,       0,  32'hC,        32'h10,      0});
        vq.push_back('{1, 1, 0, 0, 32'h0,        32'h10,       0,  32'hC,        32'h10,      0});
        vq.push_back('{1, 1, 0, 0, 32'h0,        32'h10,       0,  32'hC,        32'h10,      0});
        vq.push_back('{1, 1, 0, 0, 32'h0,        32'h10,       0,  32'hC,        32'h10,      0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h14,       0,  32'h10,       32'h14,      0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h18,       0,  32'h14,       32'h18,      0});
        vq.push_back('{0, 0, 1, 1, 32'h40,       32'h40,       1,  32'h0,        32'h0,       0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h44,       0,  32'h40,       32'h44,      0});
        vq.push_back('{1, 1, 0, 1, 32'h80,       32'h80,       0,  32'h40,       32'h44,      0});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h84,       0,  32'h80,       32'h84,      0});
        vq.push_back('{0, 0, 1, 1, 32'h102,      32'h100,      1,  32'h0,        32'h0,       1});
        vq.push_back('{0, 0, 0, 1, 32'h200,      32'h200,      0,  32'h100,      32'h104,     1});
        vq.push_back('{0, 0, 0, 0, 32'h0,        32'h204,      0,  32'h200,      32'h204,     1});
        vq.push_back('{1, 0, 0, 0, 32'h0,        32'h204,      0,  32'h204,      32'h208,     1});
        vq.push_back('{1, 0, 0, 0, 32'h0,        32'h204,      0,  32'h204,      32'h208,     1});
        vq.push_back('{0, 1, 0, 0, 32'h0,        32'h208,      0,  32'h204,      32'h208,     1});
        vq.push_back('{0, 1, 1, 0, 32'h0,        32'h20C,      1,  32'h0,        32'h0,       1});

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            set_in(v.sf, v.sd, v.fd, v.ps, v.tgt);
            @(posedge clk); #1;
            e_instr = v.bub ? NOP : mem_word(v.e_pcd);
            chk($sformatf("vec%0d.PCF", i),      PCF1,      v.e_pcf);
            chk($sformatf("vec%0d.instrD", i),   instrD1,   e_instr);
            chk($sformatf("vec%0d.PCD", i),      PCD1,      v.e_pcd);
            chk($sformatf("vec%0d.PCPlus4D", i), PCPlus4D1, v.e_pc4);
            chk($sformatf("vec%0d.validD", i),   {31'b0, validD1}, {31'b0, ~v.bub});
            chk($sformatf("vec%0d.err", i),      {31'b0, err1},    {31'b0, v.e_err});
        end

        // Async reset between edges must take effect without a clock edge
        set_in(0, 0, 0, 1, 32'h300);
        #2 rst = 1'b1;
        #1;
        chk_reset1("async_rst");
        chk("async_rst.u2.PCF", PCF2, 32'hFFFF_FFFC);
        set_in(0, 0, 0, 0, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Wrap: RESET_PC = 0xFFFF_FFFC
        @(posedge clk); #1;
        chk("wrap.PCF",      PCF2,      32'h0);
        chk("wrap.instrD",   instrD2,   mem_word(32'hFFFF_FFFC));
        chk("wrap.PCD",      PCD2,      32'hFFFF_FFFC);
        chk("wrap.PCPlus4D", PCPlus4D2, 32'h0);
        chk("wrap.err",      {31'b0, err2}, 32'h0);
        @(posedge clk); #1;
        chk("wrap2.PCF",      PCF2,      32'h4);
        chk("wrap2.PCD",      PCD2,      32'h0);
        chk("wrap2.PCPlus4D", PCPlus4D2, 32'h4);

        // Random phase on u1 against the model
        #2 rst = 1'b1;
        #1 model_reset();
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic ps;
            ps = ($urandom_range(0, 5) == 0);
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   ps ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
                   ps,
                   ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC));
            model_step();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.PCF", c),      PCF1,      m_pc);
            chk($sformatf("rnd%0d.instrD", c),   instrD1,   m_instr);
            chk($sformatf("rnd%0d.PCD", c),      PCD1,      m_pcd);
            chk($sformatf("rnd%0d.PCPlus4D", c), PCPlus4D1, m_pc4);
            chk($sformatf("rnd%0d.validD", c),   {31'b0, validD1}, {31'b0, m_valid});
            chk($sformatf("rnd%0d.err", c),      {31'b0, err1},    {31'b0, m_err});
            chk($sformatf("rnd%0d.imem_addr", c), imem1.imem_addr, m_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the RV32I 5-stage pipeline; sits directly upstream of the decode field splitter and drives its `instrD` input.
- Holds the PC and drives the instruction-memory address. Memory read is combinational.
- Applies branch/jump redirects from Execute and honours hazard-unit stall/flush.
- Registers the instruction, PC and PC+4 into Decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset/flush.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- StallF  input  1  hold PC (hazard unit).
- StallD  input  1  hold IF/ID register (hazard unit).
- FlushD  input  1  replace IF/ID contents with bubble.
- PCSrcE  input  1  redirect request from Execute (taken branch/jump).
- PCTargetE  input  32  redirect target from Execute.
- imem_addr  output  32  instruction-memory byte address (= PCF).
- imem_rdata  input  32  instruction word at imem_addr, same cycle.
- PCF  output  32  current fetch PC.
- instrD  output  32  registered instruction to Decode.
- PCD  output  32  registered PC of instrD.
- PCPlus4D  output  32  registered PC+4 of instrD.
- validD  output  1  1 = instrD is a real fetched instruction, 0 = bubble.
- misaligned_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst=1), regardless of clk:
  - PCF = RESET_PC.
  - instrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, validD = 0, misaligned_err = 0.
  - After deassertion, the first rising edge captures the instruction at RESET_PC into instrD.
- PCPlus4F = PCF + 32'd4; wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), no error.
- imem_addr = PCF, combinational.
- PC next-state, per rising edge, in priority order:
  1. PCSrcE=1: PCF <= {PCTargetE[31:2], 2'b00}. Redirect overrides StallF.
  2. StallF=1: PCF holds.
  3. Otherwise: PCF <= PCPlus4F.
- IF/ID register, per rising edge, in priority order:
  1. FlushD=1: instrD <= NOP_INSTR, validD <= 0; PCD and PCPlus4D <= 0. Flush overrides StallD.
  2. StallD=1: all IF/ID outputs hold.
  3. Otherwise: instrD <= imem_rdata, PCD <= PCF, PCPlus4D <= PCPlus4F, validD <= 1.
- Latency: PC to instrD is 1 cycle. A redirect asserted in cycle N gives fetch at the target in cycle N+1 and its instruction in instrD at N+2. The hazard unit asserts FlushD alongside PCSrcE to kill the wrong-path instruction.
- misaligned_err:
  - Set on any edge where PCSrcE=1 and PCTargetE[1:0] != 2'b00.
  - Remains set until reset.
  - Does not block the redirect; the target's low bits are cleared.
- StallF=1 with StallD=0 is legal: the same PC is re-fetched and re-registered each cycle (duplicate instruction, validD=1). The hazard unit is responsible for not requesting it.
- Reset asserted mid-stall or mid-redirect: async reset wins immediately; pending redirect is lost.
- No X propagation: all registers reset; imem_rdata is only sampled when neither FlushD nor StallD is asserted.

Test Plan:
- Reset release, imem returns addr-based words, no stalls: PCF = 0,4,8,… each cycle; instrD at cycle k equals word at 4*(k-1); validD goes 0 then 1 after the first edge.
- StallF=StallD=1 for 3 cycles with PCF=0x10: PCF stays 0x10; instrD/PCD/PCPlus4D hold (PCD=0x0C, PCPlus4D=0x10). On release PCF goes to 0x14.
- PCSrcE=1, PCTargetE=0x40, FlushD=1 at PCF=0x18:
  - Next cycle: PCF=0x40, instrD=0x00000013, validD=0.
  - Following cycle: instrD=word@0x40, PCD=0x40, PCPlus4D=0x44.
- PCSrcE=1 with StallF=1 and StallD=1 simultaneously, target 0x80: PCF=0x80 next cycle (redirect wins); IF/ID holds.
- PCSrcE=1, PCTargetE=0x0000_0102: PCF=0x100 and misaligned_err=1, which stays 1 through later redirects until rst pulses.
- Wrap and async reset:
  - RESET_PC=0xFFFF_FFFC: second fetch PCF=0x0000_0000, PCPlus4D of the first instruction = 0x0.
  - Assert rst between clock edges: PCF and all outputs return to reset values immediately, without waiting for an edge.
